// File: rtl/io_responder.sv
// Memory-mapped IO block: OUT register, free-running cycle counter, countdown
// timer (built only with IO_RESPONDER_TIMER_EN defined) and a TX FIFO.
module io_responder #(
  parameter logic [11:0] BASE_HI  = 12'hFFF,
  parameter int unsigned TX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [31:0] data_in,
  input  logic        write,
  output logic [31:0] data_out,
  output logic        hit,
  output logic [31:0] port_out,
  output logic        timer_irq,
  output logic        tx_valid,
  output logic [31:0] tx_data,
  input  logic        tx_ready
);

  localparam int unsigned PW = $clog2(TX_DEPTH);
  localparam int unsigned CW = $clog2(TX_DEPTH + 1);

  logic [3:0]  offset;
  logic        wr_en;
  logic [31:0] out_r;
  logic [31:0] cycles_r;
  logic        ovf_r;
  logic [31:0] mem [TX_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic        full;
  logic        empty;
  logic        push_req;
  logic        push_ok;
  logic        pop;
  logic        ovf_set;
  logic        exp_bit;
  logic        run_bit;
  logic [31:0] tload_rd;
  logic [31:0] tval_rd;
  logic [31:0] rd_mux;

  assign offset   = address[3:0];
  assign hit      = (address[15:4] == BASE_HI);
  assign wr_en    = write & hit;
  assign port_out = out_r;

  assign full     = (count == CW'(TX_DEPTH));
  assign empty    = (count == '0);
  assign tx_valid = ~empty;
  assign tx_data  = tx_valid ? mem[rd_ptr] : '0;
  assign pop      = tx_valid & tx_ready;
  assign push_req = wr_en && (offset == 4'd5);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok  = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_r    <= '0;
      cycles_r <= '0;
      ovf_r    <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      cycles_r <= cycles_r + 32'd1;
      if (wr_en && offset == 4'd0) out_r <= data_in;
      ovf_r <= ovf_set | (ovf_r & ~(wr_en && offset == 4'd4 && data_in[4]));
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem[wr_ptr] <= data_in;
  end

`ifdef IO_RESPONDER_TIMER_EN
  typedef enum logic {T_IDLE, T_RUN} tstate_t;
  tstate_t     tstate;
  logic [31:0] tload_r;
  logic [31:0] tval_r;
  logic        exp_r;
  logic        tload_wr;
  logic        exp_set;

  assign tload_wr = wr_en && (offset == 4'd2);
  // A reload on the expiring cycle wins, so no expiry is flagged then.
  assign exp_set  = (tstate == T_RUN) && (tval_r == 32'd1) && !tload_wr;

  always_ff @(posedge clk) begin
    if (reset) begin
      tstate  <= T_IDLE;
      tload_r <= '0;
      tval_r  <= '0;
      exp_r   <= 1'b0;
    end else begin
      exp_r <= exp_set | (exp_r & ~(wr_en && offset == 4'd4 && data_in[0]));
      if (tload_wr) begin
        tload_r <= data_in;
        tval_r  <= data_in;
        tstate  <= (data_in != '0) ? T_RUN : T_IDLE;
      end else if (tstate == T_RUN) begin
        tval_r <= tval_r - 32'd1;
        if (tval_r == 32'd1) tstate <= T_IDLE;
      end
    end
  end

  assign exp_bit  = exp_r;
  assign run_bit  = (tstate == T_RUN);
  assign tload_rd = tload_r;
  assign tval_rd  = tval_r;
`else
  assign exp_bit  = 1'b0;
  assign run_bit  = 1'b0;
  assign tload_rd = '0;
  assign tval_rd  = '0;
`endif

  assign timer_irq = exp_bit;

  always_comb begin
    rd_mux = '0;
    case (offset)
      4'd0: rd_mux = out_r;
      4'd1: rd_mux = cycles_r;
      4'd2: rd_mux = tload_rd;
      4'd3: rd_mux = tval_rd;
      4'd4: rd_mux = {27'd0, ovf_r, empty, full, run_bit, exp_bit};
      default: rd_mux = '0;
    endcase
  end

  assign data_out = hit ? rd_mux : '0;

endmodule

// File: doc/io_responder.md
IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 The block SHALL have parameter BASE_HI, default 12'hFFF, meaning address[15:4] value that selects the block (16 word registers).
REQ-002 The block SHALL have parameter TX_DEPTH, default 4, meaning TX FIFO entries (power of two, 2..16).
REQ-003 The block SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port address  input  16  CPU word address (CPU MAR).
REQ-006 The block SHALL have port data_in  input  32  CPU write data (CPU MBR_W).
REQ-007 The block SHALL have port write  input  1  CPU write strobe, one cycle per write.
REQ-008 The block SHALL have port data_out  output  32  read data to CPU MBR_R mux.
REQ-009 The block SHALL have port hit  output  1  address in block range; top level selects data_out over memory and gates memory write.
REQ-010 The block SHALL have port port_out  output  32  OUT register value.
REQ-011 The block SHALL have port timer_irq  output  1  equals STATUS.EXP.
REQ-012 The block SHALL have port tx_valid  output  1  TX FIFO not empty.
REQ-013 The block SHALL have port tx_data  output  32  TX FIFO head word.
REQ-014 The block SHALL have port tx_ready  input  1  consumer accepts head when tx_valid & tx_ready at clk edge.

Function
REQ-015 hit SHALL be combinational: address[15:4]==BASE_HI; offset = address[3:0].
REQ-016 data_out SHALL be combinational from current register state (zero read latency); 0 when hit=0 or offset unmapped.
REQ-017 Writes SHALL commit at the clk edge where write & hit; writes to RO or unmapped offsets ignored.
REQ-018 Offset 0 OUT: RW, drives port_out.
REQ-019 Offset 1 CYCLES: RO, +1 every cycle, wraps 32'hFFFFFFFF -> 0.
REQ-020 Offset 2 TLOAD: RW; write of N>0 loads TVAL=N, timer -> RUN; write of 0 -> IDLE, TVAL=0.
REQ-021 Offset 3 TVAL: RO current count.
REQ-022 Timer FSM IDLE/RUN: RUN decrements TVAL each cycle; on TVAL 1->0 sets EXP, -> IDLE; TLOAD write in RUN reloads (last write wins over decrement).
REQ-023 Offset 4 STATUS: bit0 EXP sticky (write 1 clears), bit1 RUN, bit2 FULL, bit3 EMPTY, bit4 OVF sticky (write 1 clears); other bits 0.
REQ-024 Set SHALL win over write-1-clear for EXP and OVF in the same cycle.
REQ-025 Offset 5 TXDATA: WO (reads 0); write pushes data_in to FIFO tail.
REQ-026 Push when full without same-cycle pop SHALL drop the word and set OVF; push and pop in the same cycle when full SHALL both succeed.
REQ-027 Pop on tx_valid & tx_ready; tx_data/tx_valid registered from FIFO state, first word visible the cycle after push.
REQ-028 Pointers SHALL wrap modulo TX_DEPTH; occupancy counter 0..TX_DEPTH.

Reset
REQ-029 On reset at clk edge: OUT=0, CYCLES=0, TLOAD=0, TVAL=0, timer IDLE, EXP=0, OVF=0, FIFO empty (tx_valid=0, tx_data=0); timer_irq=0.
REQ-030 Reset SHALL override a concurrent write, push or pop; mid-countdown reset returns to IDLE with no EXP.

Configuration
REQ-031 Macro IO_RESPONDER_TIMER_EN: defined -> timer per REQ-020..022; undefined -> no timer logic, offsets 2/3 read 0, writes ignored, STATUS bits 0-1 read 0, timer_irq tied 0.

Verification
REQ-032 Reset, read offsets 0-5 -> all 0 except STATUS=32'h8; CYCLES read 10 cycles after reset release = 10.
REQ-033 Write 32'hDEADBEEF to 16'hFFF0 -> port_out=32'hDEADBEEF next cycle; read 16'h0010 -> hit=0, data_out=0.
REQ-034 Write TLOAD=3 -> TVAL 3,2,1,0 over following cycles, EXP=1 and timer_irq=1 on 3rd edge after load; write STATUS=1 -> EXP=0.
REQ-035 tx_ready=0, push 5 words 1..5 -> FULL=1, OVF=1, word 5 dropped; tx_ready=1 -> tx_data 1,2,3,4 on consecutive cycles then tx_valid=0.
REQ-036 FIFO full, push 9 with tx_ready=1 same cycle -> no OVF, word 9 delivered after word 4.
REQ-037 Macro undefined: write TLOAD=5 -> TVAL reads 0, timer_irq stays 0 for 10 cycles.
